gtx_link_manager: RTL
=====================

Name: gtx_link_manager

Overview:
- Parametrised reset-sequencing and link-supervision controller for an N-lane Aurora 64b66b GTX array.
- Generates GT/user resets with a programmable hold time, and debounces per-lane channel_up & lane_up.
- Declares the array up, and automatically re-initialises on link-up timeout or link drop, giving up after MAX_RETRY attempts.
- Sits between the system reset and the per-lane Aurora subsystems; status outputs feed VIO/core logic.

Parameters:
- NUM_LANES, 4, number of GTX lanes supervised.
- RST_CYCLES, 1000, init_clk cycles gt_rst is held after a reset or re-init request.
- RST_STAGGER, 16, extra cycles reset (user) stays high after gt_rst falls.
- DEBOUNCE, 64, consecutive cycles a lane's raw up must hold before gtp_up asserts.
- LINK_TIMEOUT, 1000000, cycles allowed in WAIT_UP before a retry.
- MAX_RETRY, 7, consecutive failed attempts before entering FAIL.
- CNT_W, 20, width of the shared hold/timeout counter; must hold max(RST_CYCLES, LINK_TIMEOUT).

Ports:
- init_clk  in  1  free-running clock; all logic on its rising edge.
- gtp_reset  in  1  synchronous active-high reset.
- lane_enable  in  NUM_LANES  lanes required for all_up; disabled lanes are ignored.
- channel_up  in  NUM_LANES  per-lane Aurora channel_up (async to init_clk).
- lane_up  in  NUM_LANES  per-lane Aurora lane_up (async to init_clk).
- qpll_lock  in  1  common QPLL lock (async).
- force_reinit  in  1  one-cycle pulse: restart sequencing and clear retry_cnt.
- gt_rst  out  1  to Aurora gt_reset.
- reset  out  1  to Aurora user reset.
- gtp_up  out  NUM_LANES  debounced per-lane up.
- all_up  out  1  all enabled lanes up, state RUN.
- link_fail  out  1  sticky; asserted in FAIL.
- retry_cnt  out  clog2(MAX_RETRY+1)  consecutive failed attempts.
- drop_cnt  out  8  saturating count of RUN→re-init link drops.
- state_o  out  3  FSM state code.

Behaviour:
- Reset is synchronous and active-high: gtp_reset sampled high at an init_clk edge sets gt_rst=1, reset=1, gtp_up=0, all_up=0, link_fail=0, retry_cnt=0, drop_cnt=0, counters=0, state=RST_HOLD.
- Synchronisers:
  - channel_up, lane_up and qpll_lock each pass through 2-flop synchronisers.
  - raw[i] = sync(channel_up[i]) & sync(lane_up[i]); this adds 2 cycles of latency.
- Debounce, per lane:
  - The counter increments while raw[i]=1 & lane_enable[i]=1.
  - gtp_up[i] sets the cycle after the counter reaches DEBOUNCE-1.
  - raw[i]=0 or lane_enable[i]=0 clears the counter and gtp_up[i] on the next edge (fast drop).
  - Debouncers are cleared while gt_rst=1.
- Condition definitions:
  - up_ok = (lane_enable != 0) & ((gtp_up & lane_enable) == lane_enable).
  - drop = any enabled lane with gtp_up falling.
- FSM codes: RST_HOLD=0, STAGGER=1, WAIT_UP=2, RUN=3, FAIL=4.
- RST_HOLD:
  - gt_rst=1, reset=1, and cnt increments.
  - At cnt==RST_CYCLES-1 → STAGGER with cnt=0, so gt_rst is high for exactly RST_CYCLES cycles in this state.
- STAGGER:
  - gt_rst=0, reset=1.
  - At cnt==RST_STAGGER-1 → WAIT_UP with cnt=0.
- WAIT_UP:
  - gt_rst=0, reset=0.
  - cnt increments only while sync(qpll_lock)=1 and lane_enable != 0; otherwise cnt holds (no timeout with an empty mask).
  - up_ok → RUN and retry_cnt=0.
  - Otherwise, cnt==LINK_TIMEOUT-1: if retry_cnt==MAX_RETRY → FAIL; else retry_cnt+1 → RST_HOLD.
  - up_ok wins over timeout in the same cycle.
- RUN:
  - all_up=1 is registered and asserts the cycle after entry.
  - If drop occurs: all_up=0, drop_cnt+1 (saturating at 255) → RST_HOLD; retry_cnt is unchanged.
  - A lane_enable change that keeps up_ok stays in RUN.
- FAIL:
  - gt_rst=1, reset=1, link_fail=1.
  - Held until force_reinit or gtp_reset.
- force_reinit, in any state: next state RST_HOLD, cnt=0, retry_cnt=0, link_fail=0, all_up=0; drop_cnt is kept.
- Priority: gtp_reset > force_reinit > state transitions.
- gtp_reset or force_reinit arriving mid-RST_HOLD restarts the full hold count.

Test Plan:
- Counter-based tests use RST_CYCLES=10, RST_STAGGER=4, DEBOUNCE=8, LINK_TIMEOUT=50, MAX_RETRY=2, NUM_LANES=4.
- Release gtp_reset, lane_enable=4'b0011, lanes 0–1 up at WAIT_UP entry, qpll_lock=1 → gt_rst high for 10 cycles, reset falls 4 cycles later; gtp_up=4'b0011 after 2+8 cycles; all_up=1 one cycle after RUN; state_o=3.
- No lanes up, lock=1 → three WAIT_UP timeouts of 50 cycles each, with retry_cnt 1→2 → then FAIL: link_fail=1, gt_rst=1, state_o=4; force_reinit pulse → retry_cnt=0, link_fail=0, state_o=0.
- RUN, then lane 1 channel_up low for 1 cycle → gtp_up[1]=0 within 3 cycles, all_up=0, drop_cnt=1, state→RST_HOLD, retry_cnt unchanged.
- Glitchy lane_up (high 5, low 1, repeated) → gtp_up stays 0 and no RUN entry; timeout fires at 50 counted cycles.
- qpll_lock=0 in WAIT_UP for 200 cycles → no timeout, retry_cnt=0; lane_enable=0 → all_up never asserts.
- Assert gtp_reset for one cycle mid-RUN → all outputs return to reset values next edge, including drop_cnt=0.

Source files
------------

// File: rtl/gtx_link_manager.sv
// Reset sequencing and link supervision for an N-lane Aurora 64b66b GTX array:
// staged GT/user resets, per-lane debounce, link-up timeout with bounded retries.
module gtx_link_manager #(
    parameter  int NUM_LANES    = 4,
    parameter  int RST_CYCLES   = 1000,
    parameter  int RST_STAGGER  = 16,
    parameter  int DEBOUNCE     = 64,
    parameter  int LINK_TIMEOUT = 1000000,
    parameter  int MAX_RETRY    = 7,
    parameter  int CNT_W        = 20,
    localparam int RETRY_W      = $clog2(MAX_RETRY + 1)
) (
    input  logic                 init_clk,
    input  logic                 gtp_reset,
    input  logic [NUM_LANES-1:0] lane_enable,
    input  logic [NUM_LANES-1:0] channel_up,
    input  logic [NUM_LANES-1:0] lane_up,
    input  logic                 qpll_lock,
    input  logic                 force_reinit,
    output logic                 gt_rst,
    output logic                 reset,
    output logic [NUM_LANES-1:0] gtp_up,
    output logic                 all_up,
    output logic                 link_fail,
    output logic [RETRY_W-1:0]   retry_cnt,
    output logic [7:0]           drop_cnt,
    output logic [2:0]           state_o
);

    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_STAGGER  = 3'd1,
        ST_WAIT_UP  = 3'd2,
        ST_RUN      = 3'd3,
        ST_FAIL     = 3'd4
    } state_t;

    logic [NUM_LANES-1:0] cu_meta_r, cu_sync_r, lu_meta_r, lu_sync_r;
    logic                 lock_meta_r, lock_sync_r;
    logic [DB_W-1:0]      db_cnt_r [NUM_LANES];
    logic [NUM_LANES-1:0] gtp_up_r, gtp_prev_r;
    logic [NUM_LANES-1:0] raw_s;
    logic                 up_ok_s, drop_s, cnt_en_s;

    state_t               state_r, state_nx_s;
    logic [CNT_W-1:0]     cnt_r, cnt_nx_s;
    logic [RETRY_W-1:0]   retry_r, retry_nx_s;
    logic [7:0]           drop_r, drop_nx_s;
    logic                 gt_rst_r, reset_r, all_up_r, link_fail_r;
    logic                 gt_rst_nx_s, reset_nx_s, all_up_nx_s, link_fail_nx_s;

    // Two-flop synchronisers for the asynchronous transceiver status inputs
    always_ff @(posedge init_clk) begin
        if (gtp_reset) begin
            cu_meta_r   <= '0;
            cu_sync_r   <= '0;
            lu_meta_r   <= '0;
            lu_sync_r   <= '0;
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            cu_meta_r   <= channel_up;
            cu_sync_r   <= cu_meta_r;
            lu_meta_r   <= lane_up;
            lu_sync_r   <= lu_meta_r;
            lock_meta_r <= qpll_lock;
            lock_sync_r <= lock_meta_r;
        end
    end

    assign raw_s = cu_sync_r & lu_sync_r;

    // Per-lane debounce: slow rise after DEBOUNCE clean cycles, immediate drop
    always_ff @(posedge init_clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (gtp_reset || gt_rst_r || !raw_s[i] || !lane_enable[i]) begin
                db_cnt_r[i] <= '0;
                gtp_up_r[i] <= 1'b0;
            end else if (db_cnt_r[i] == DB_W'(DEBOUNCE - 1)) begin
                db_cnt_r[i] <= db_cnt_r[i];
                gtp_up_r[i] <= 1'b1;
            end else begin
                db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                gtp_up_r[i] <= 1'b0;
            end
        end
    end

    // Previous debounced state, for falling-edge (drop) detection
    always_ff @(posedge init_clk) begin
        if (gtp_reset) begin
            gtp_prev_r <= '0;
        end else begin
            gtp_prev_r <= gtp_up_r;
        end
    end

    assign up_ok_s  = (lane_enable != {NUM_LANES{1'b0}}) && ((gtp_up_r & lane_enable) == lane_enable);
    assign drop_s   = |(gtp_prev_r & ~gtp_up_r & lane_enable);
    assign cnt_en_s = lock_sync_r && (lane_enable != {NUM_LANES{1'b0}});

    // FSM state and registered outputs
    always_ff @(posedge init_clk) begin
        if (gtp_reset) begin
            state_r     <= ST_RST_HOLD;
            cnt_r       <= '0;
            retry_r     <= '0;
            drop_r      <= 8'd0;
            gt_rst_r    <= 1'b1;
            reset_r     <= 1'b1;
            all_up_r    <= 1'b0;
            link_fail_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            retry_r     <= retry_nx_s;
            drop_r      <= drop_nx_s;
            gt_rst_r    <= gt_rst_nx_s;
            reset_r     <= reset_nx_s;
            all_up_r    <= all_up_nx_s;
            link_fail_r <= link_fail_nx_s;
        end
    end

    // Next-state, shared hold/timeout counter and retry/drop bookkeeping
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        retry_nx_s = retry_r;
        drop_nx_s  = drop_r;
        if (force_reinit) begin
            state_nx_s = ST_RST_HOLD;
            cnt_nx_s   = '0;
            retry_nx_s = '0;
        end else begin
            case (state_r)
                ST_RST_HOLD: begin
                    if (cnt_r == CNT_W'(RST_CYCLES - 1)) begin
                        state_nx_s = ST_STAGGER;
                        cnt_nx_s   = '0;
                    end else begin
                        cnt_nx_s   = cnt_r + CNT_W'(1);
                    end
                end
                ST_STAGGER: begin
                    if (cnt_r == CNT_W'(RST_STAGGER - 1)) begin
                        state_nx_s = ST_WAIT_UP;
                        cnt_nx_s   = '0;
                    end else begin
                        cnt_nx_s   = cnt_r + CNT_W'(1);
                    end
                end
                ST_WAIT_UP: begin
                    if (up_ok_s) begin
                        state_nx_s = ST_RUN;
                        cnt_nx_s   = '0;
                        retry_nx_s = '0;
                    end else if (cnt_en_s) begin
                        if (cnt_r == CNT_W'(LINK_TIMEOUT - 1)) begin
                            cnt_nx_s = '0;
                            if (retry_r == RETRY_W'(MAX_RETRY)) begin
                                state_nx_s = ST_FAIL;
                            end else begin
                                state_nx_s = ST_RST_HOLD;
                                retry_nx_s = retry_r + RETRY_W'(1);
                            end
                        end else begin
                            cnt_nx_s = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        cnt_nx_s = cnt_r;
                    end
                end
                ST_RUN: begin
                    if (drop_s) begin
                        state_nx_s = ST_RST_HOLD;
                        cnt_nx_s   = '0;
                        if (drop_r != 8'hFF) begin
                            drop_nx_s = drop_r + 8'd1;
                        end else begin
                            drop_nx_s = drop_r;
                        end
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end
                ST_FAIL: begin
                    state_nx_s = ST_FAIL;
                    cnt_nx_s   = '0;
                end
                default: begin
                    state_nx_s = ST_RST_HOLD;
                    cnt_nx_s   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so outputs line up with the state register
    always_comb begin
        gt_rst_nx_s    = (state_nx_s == ST_RST_HOLD) || (state_nx_s == ST_FAIL);
        reset_nx_s     = (state_nx_s != ST_WAIT_UP) && (state_nx_s != ST_RUN);
        link_fail_nx_s = (state_nx_s == ST_FAIL);
        all_up_nx_s    = (state_r == ST_RUN) && (state_nx_s == ST_RUN) && up_ok_s;
    end

    assign gt_rst    = gt_rst_r;
    assign reset     = reset_r;
    assign gtp_up    = gtp_up_r;
    assign all_up    = all_up_r;
    assign link_fail = link_fail_r;
    assign retry_cnt = retry_r;
    assign drop_cnt  = drop_r;
    assign state_o   = state_r;

endmodule
